// File: rtl/bam_pkg.sv
// Shared types and helpers for the sequential broken-array multiplier.
// bam_ref gives the golden approximate product for any operand width up to 64.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic int hw_of(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int vw_of(input int n);
        return $clog2(2 * n);
    endfunction

    // Sums every kept partial-product bit a[i]&b[j] at weight 2^(i+j).
    function automatic logic [127:0] bam_ref(input int n, input logic [63:0] a,
                                             input logic [63:0] b, input int h,
                                             input int v);
        logic [127:0] acc;
        acc = '0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                if (a[i] && b[j] && (j >= h) && ((i + j) >= v)) begin
                    acc = acc + (128'(1) << (i + j));
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bam_row_mask.sv
// One shifted partial-product row of the multiplicand with the vertical cut applied:
// bit i survives only when i + rowIdx_i reaches vCut_i.
module bam_row_mask
    import bam_pkg::*;
#(
    parameter int N  = 8,
    parameter int HW = hw_of(N),
    parameter int VW = vw_of(N)
) (
    input  logic [N-1:0]   a_i,
    input  logic [HW-1:0]  rowIdx_i,
    input  logic [VW-1:0]  vCut_i,
    output logic [2*N-1:0] row_o
);

    logic [N-1:0] aMasked;

    always_comb begin
        aMasked = '0;
        for (int i = 0; i < N; i++) begin
            if ((i + int'(rowIdx_i)) >= int'(vCut_i)) begin
                aMasked[i] = a_i[i];
            end
        end
    end

    assign row_o = {{N{1'b0}}, aMasked} << rowIdx_i;

endmodule

// File: rtl/seq_bam_mult.sv
// Sequential broken-array multiplier: one partial-product row per clock into a
// 2N-bit accumulator, with runtime horizontal/vertical cuts latched per transaction.
module seq_bam_mult
    import bam_pkg::*;
#(
    parameter int N  = 8,
    parameter int HW = hw_of(N),
    parameter int VW = vw_of(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [HW-1:0]  h_cut,
    input  logic [VW-1:0]  v_cut,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam logic [HW-1:0] ROWS = HW'(N);

    state_e         state_q, state_d;
    logic [N-1:0]   aOp_q, aOp_d;
    logic [N-1:0]   bOp_q, bOp_d;
    logic [VW-1:0]  vCut_q, vCut_d;
    logic [HW-1:0]  row_q, row_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic [2*N-1:0] rowMasked;
    logic           bBit;

    bam_row_mask #(
        .N (N),
        .HW(HW),
        .VW(VW)
    ) u_row_mask (
        .a_i     (aOp_q),
        .rowIdx_i(row_q),
        .vCut_i  (vCut_q),
        .row_o   (rowMasked)
    );

    // A shifted one-hot select stays in range even when row_q has reached N.
    assign bBit = |(bOp_q & (N'(1) << row_q));

    always_comb begin
        state_d   = state_q;
        aOp_d     = aOp_q;
        bOp_d     = bOp_q;
        vCut_d    = vCut_q;
        row_d     = row_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    aOp_d   = a;
                    bOp_d   = b;
                    vCut_d  = v_cut;
                    acc_d   = '0;
                    row_d   = (h_cut > ROWS) ? ROWS : h_cut;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (row_q < ROWS) begin
                    acc_d = acc_q + (bBit ? rowMasked : '0);
                    row_d = row_q + 1'b1;
                end
                // The result register only changes here, so it holds through later transactions.
                if (row_d >= ROWS) begin
                    prod_d  = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aOp_q   <= '0;
            bOp_q   <= '0;
            vCut_q  <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            aOp_q   <= aOp_d;
            bOp_q   <= bOp_d;
            vCut_q  <= vCut_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_seq_bam_mult.sv
// Randomized and directed bench for seq_bam_mult (N=8) against a bit-sum reference model.
module tb_seq_bam_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  h_cut;
    logic [3:0]  v_cut;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    seq_bam_mult #(.N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .h_cut    (h_cut),
        .v_cut    (v_cut),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every product bit a[i]&b[j] that survives both cuts adds 2^(i+j).
    function automatic int refProduct(input int av, input int bv, input int h, input int v);
        int r;
        r = 0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                if ((((av >> i) & 1) == 1) && (((bv >> j) & 1) == 1) && (j >= h) && ((i + j) >= v)) begin
                    r = r + (1 << (i + j));
                end
            end
        end
        return r;
    endfunction

    function automatic int refCalcCycles(input int h);
        return (h >= 8) ? 1 : (8 - h);
    endfunction

    // Runs one transaction; edges counts the accept edge as 1 and stops at the edge after which out_valid is seen.
    task automatic applyStimulus(input int av, input int bv, input int h, input int v,
                                 input int holdCycles, output int got, output int edges);
        int budget;
        @(negedge clk);
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("in_ready before accept", 32'(in_ready), 1);
        a         = 8'(av);
        b         = 8'(bv);
        h_cut     = 4'(h);
        v_cut     = 4'(v);
        in_valid  = 1'b1;
        out_ready = (holdCycles == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        h_cut    = 4'($urandom);
        v_cut    = 4'($urandom);
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (!out_valid) begin
                in_valid = 1'b1;
            end
        end
        in_valid = 1'b0;
        checkOutput("out_valid arrives", 32'(out_valid), 1);
        checkOutput("in_ready low in DONE", 32'(in_ready), 0);
        got = int'(product);
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk);
            #1;
            checkOutput("backpressure out_valid", 32'(out_valid), 1);
            checkOutput("backpressure product", 32'(product), 32'(got));
            checkOutput("backpressure in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("out_valid after handshake", 32'(out_valid), 0);
        checkOutput("in_ready after handshake", 32'(in_ready), 1);
        checkOutput("product held after handshake", 32'(product), 32'(got));
    endtask

    // Directed cases: operands, cuts, backpressure cycles, fixed expected product (-1: model only).
    int tblA[8]    = '{255, 255, 8'h80, 8'h0F, 8'hA5, 255, 3, 200};
    int tblB[8]    = '{255, 255, 8'h80, 8'hFF, 8'h3C, 255, 5, 100};
    int tblH[8]    = '{0,   5,   5,     5,     8,     0,   0, 2};
    int tblV[8]    = '{0,   11,  11,    11,    0,     15,  0, 4};
    int tblHold[8] = '{5,   0,   0,     0,     0,     0,   0, 0};
    int tblExp[8]  = '{65025, 51200, 16384, 0, 0, 0, 15, -1};

    initial begin
        int got;
        int edges;
        int lastProd;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        h_cut     = '0;
        v_cut     = '0;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 1);
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset product", 32'(product), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            applyStimulus(tblA[k], tblB[k], tblH[k], tblV[k], tblHold[k], got, edges);
            checkOutput($sformatf("directed %0d product", k), 32'(got),
                        32'(refProduct(tblA[k], tblB[k], tblH[k], tblV[k])));
            if (tblExp[k] >= 0) begin
                checkOutput($sformatf("directed %0d plan value", k), 32'(got), 32'(tblExp[k]));
            end
            checkOutput($sformatf("directed %0d latency", k), 32'(edges),
                        32'(refCalcCycles(tblH[k]) + 1));
        end

        for (int k = 0; k < 25; k++) begin
            int av, bv, h, v, hold;
            av   = int'($urandom_range(0, 255));
            bv   = int'($urandom_range(0, 255));
            h    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            v    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 2));
            applyStimulus(av, bv, h, v, hold, got, edges);
            checkOutput($sformatf("random %0d a=%0d b=%0d h=%0d v=%0d", k, av, bv, h, v),
                        32'(got), 32'(refProduct(av, bv, h, v)));
            checkOutput($sformatf("random %0d latency", k), 32'(edges), 32'(refCalcCycles(h) + 1));
        end

        // Abort an exact 255*255 run in its third CALC cycle.
        lastProd = int'(product);
        @(negedge clk);
        a        = 8'd255;
        b        = 8'd255;
        h_cut    = 4'd0;
        v_cut    = 4'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("product held during CALC", 32'(product), 32'(lastProd));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-reset out_valid", 32'(out_valid), 0);
        checkOutput("mid-reset in_ready", 32'(in_ready), 1);
        checkOutput("mid-reset product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("no stale out_valid", 32'(out_valid), 0);
        end
        applyStimulus(7, 9, 0, 0, 0, got, edges);
        checkOutput("post-reset 7*9", 32'(got), 63);
        checkOutput("post-reset latency", 32'(edges), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bam_mult.md
Name: seq_bam_mult

Overview:
- Parametrised, sequential successor to the flat combinational broken-array multipliers (BAM).
- Computes the unsigned approximate product of two N-bit operands.
- Horizontal cut H and vertical cut V are runtime inputs, latched per transaction, instead of being fixed at generation time.
- Processes one partial-product row per clock with a shift-add accumulator, behind valid/ready handshakes on both the operand side and the result side.

Parameters:
- N, default 8: operand width in bits (N >= 2).
- HW, default $clog2(N+1): width of the h_cut input; encodes 0..N.
- VW, default $clog2(2*N): width of the v_cut input; encodes 0..2N-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and cuts are presented.
- in_ready  out  1  block can accept a transaction.
- a  in  N  multiplicand, unsigned.
- b  in  N  multiplier, unsigned.
- h_cut  in  HW  rows j < h_cut are dropped.
- v_cut  in  VW  partial-product bits with i+j < v_cut are dropped.
- out_valid  out  1  product is available.
- out_ready  in  1  consumer takes the product.
- product  out  2N  approximate product, unsigned.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- BAM rule: partial-product bit a[i]&b[j] is kept iff j >= h_cut AND i+j >= v_cut.
  - product = sum of kept bits, each weighted 2^(i+j).
  - The result is always <= a*b, so it never exceeds 2N bits. No truncation or saturation occurs. The MSB is a true sum bit, not tied to zero.
  - h_cut=0 with v_cut=0 gives the exact product.
  - h_cut >= N, or v_cut > 2N-2, gives product 0.
- Reset values:
  - state = IDLE.
  - in_ready = 1 (combinational from state).
  - out_valid = 0.
  - product, the accumulator, the row counter and the latched operands/cuts are all 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On the in_valid & in_ready edge, latch a, b, h_cut, v_cut; clear the accumulator; set row = min(h_cut, N); go to CALC.
  - CALC: each cycle, if row < N then acc += masked_row(row) and row++.
    - Leave CALC when row has reached N after the update, or immediately if it entered with row = N. In both cases the next state is DONE.
    - CALC therefore lasts L = max(N - h_cut, 1) cycles.
  - DONE: out_valid=1 and product = acc.
    - On out_valid & out_ready, go to IDLE.
    - product holds its value after the handshake until the next result overwrites it.
- Latency: out_valid rises exactly L+1 rising edges after the accept edge.
- Throughput: one transaction per L+2 cycles when out_ready is held at 1.
- in_ready is 0 throughout CALC and DONE. in_valid is ignored there, and the operand inputs may change freely without effect.
- Backpressure: in DONE with out_ready=0, out_valid and product hold stable indefinitely.
- masked_row(j) is combinational: (a & amask(j)) << j, where amask bit i = (i+j >= v_cut).
  - The accumulator is 2N bits wide.
  - The row sum cannot overflow, because the accumulated value is a subset sum of a*b.
- Reset mid-operation: asserting rst_n=0 in any state returns to the reset values immediately. The in-flight transaction is lost and no out_valid is produced for it.
- Simultaneous events: none cross states, because in_ready and out_valid are never both 1. A back-to-back accept occurs no earlier than the cycle after the output handshake.

Decomposition:
- Shared package bam_pkg, holding:
  - the state enum (IDLE, CALC, DONE);
  - functions hw_of(N) and vw_of(N);
  - a function bam_ref(a, b, h, v) used by the bench scoreboard.
- One natural combinational sub-module, bam_row_mask.
  - Parameter N.
  - Inputs: a, row index j, v_cut.
  - Output: the 2N-bit shifted, masked row.
- The FSM, counter and accumulator stay in seq_bam_mult.

Test Plan:
- Exact mode: N=8, a=255, b=255, h=0, v=0 -> product=65025; out_valid 9 edges after accept.
- Cut mode: a=255, b=255, h=5, v=11 -> product=51200 (rows 5/6/7 contribute 6144+14336+30720); L=3, out_valid 4 edges after accept.
- Corner values with h=5, v=11:
  - a=0x80, b=0x80 -> 16384.
  - a=0x0F, b=0xFF -> 0, because every remaining bit has i+j < 11.
- Degenerate cuts:
  - h=8 with any a/b -> product=0, out_valid 2 edges after accept.
  - h=0, v=15, a=b=255 -> 0.
- Backpressure and ordering:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and product stable, in_ready=0.
  - Then issue two back-to-back transactions (3*5 exact, then 200*100 with h=2, v=4); both must match bam_ref, in order.
- Reset in CALC:
  - Assert rst_n low at cycle 3 of an exact 255*255 run -> out_valid=0, in_ready=1, product=0 immediately, with no stale output.
  - Then 7*9 exact -> 63.
